letter_pool: RTL and testbench

Falling-letter pool for the typing game, directly downstream of the random letter generator. Holds up to `SLOTS` on-screen letters. Spawns a new letter from the generator's `ch/speed/x/y` outputs every `SPAWN_PERIOD` frames and advances every live letter by its speed on each frame tick. Retires letters when the player types them (hit) or when they reach the bottom (miss). Exposes a slot read port to the VGA renderer and hit/miss counters to the score display.

---
 rtl/letter_pkg.sv | 17 +
 rtl/letter_pick.sv | 39 +++
 rtl/letter_pool.sv | 123 ++++++++++++
 tb/tb_letter_pool.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/letter_pkg.sv
// Shared slot record and default sizing for the falling-letter pool.
package letter_pkg;

    localparam int SLOTS_D        = 8;
    localparam int BOTTOM_D       = 480;
    localparam int SPAWN_PERIOD_D = 30;
    localparam int IDX_W          = $clog2(SLOTS_D);

    typedef struct packed {
        logic       active;
        logic [7:0] ch;
        logic [2:0] speed;
        logic [8:0] x;
        logic [9:0] y;
    } letter_t;

endpackage

// File: rtl/letter_pick.sv
// Combinational slot selection: first free slot, and the deepest slot matching a key.
module letter_pick
    import letter_pkg::*;
#(
    parameter int SLOTS = SLOTS_D,
    localparam int IDX_W = $clog2(SLOTS)
) (
    input  letter_t [SLOTS-1:0] slots,
    input  logic [7:0]          key_ascii,
    output logic                free_ok,
    output logic [IDX_W-1:0]    free_idx,
    output logic                match_ok,
    output logic [IDX_W-1:0]    match_idx
);

    logic [8:0] best_x;

    always_comb begin
        free_ok   = 1'b0;
        free_idx  = '0;
        match_ok  = 1'b0;
        match_idx = '0;
        best_x    = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!free_ok && !slots[i].active) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(i);
            end
            // strict > keeps the lowest index on equal depth
            if (slots[i].active && slots[i].ch == key_ascii &&
                (!match_ok || slots[i].x > best_x)) begin
                match_ok  = 1'b1;
                match_idx = IDX_W'(i);
                best_x    = slots[i].x;
            end
        end
    end

endmodule

// File: rtl/letter_pool.sv
// Falling-letter pool: spawns, moves and retires on-screen letters; keeps hit/miss counts.
module letter_pool
    import letter_pkg::*;
#(
    parameter int SLOTS        = SLOTS_D,
    parameter int BOTTOM       = BOTTOM_D,
    parameter int SPAWN_PERIOD = SPAWN_PERIOD_D,
    localparam int IDX_W = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             run,
    input  logic             frame_tick,
    input  logic [7:0]       gen_ch,
    input  logic [2:0]       gen_speed,
    input  logic [8:0]       gen_x,
    input  logic [9:0]       gen_y,
    input  logic             key_valid,
    input  logic [7:0]       key_ascii,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_active,
    output logic [7:0]       rd_ch,
    output logic [8:0]       rd_x,
    output logic [9:0]       rd_y,
    output logic             hit,
    output logic             miss,
    output logic             wrong,
    output logic [15:0]      score,
    output logic [15:0]      miss_cnt,
    output logic [IDX_W:0]   live_cnt
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    letter_t [SLOTS-1:0] slots, slots_nx;
    logic [CNT_W-1:0]    spawn_cnt;
    logic                spawn_pend;
    logic                free_ok, match_ok, key_hit, spawn_wrap;
    logic [IDX_W-1:0]    free_idx, match_idx;
    logic [IDX_W:0]      miss_n, pop;
    logic [9:0]          sum;
    logic [16:0]         miss_sum;

    letter_pick #(.SLOTS(SLOTS)) u_pick (
        .slots     (slots),
        .key_ascii (key_ascii),
        .free_ok   (free_ok),
        .free_idx  (free_idx),
        .match_ok  (match_ok),
        .match_idx (match_idx)
    );

    assign key_hit    = key_valid && match_ok;
    assign spawn_wrap = (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1));

    // key, motion and spawn all read the pre-update slots; they touch disjoint slots
    always_comb begin
        slots_nx = slots;
        miss_n   = '0;
        sum      = '0;
        pop      = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            pop = pop + (IDX_W+1)'(slots[i].active);
            if (frame_tick && slots[i].active && !(key_hit && match_idx == IDX_W'(i))) begin
                sum = {1'b0, slots[i].x} + {7'b0, slots[i].speed};
                if (sum >= 10'(BOTTOM)) begin
                    slots_nx[i] = '0;
                    miss_n      = miss_n + 1'b1;
                end else begin
                    slots_nx[i].x = sum[8:0];
                end
            end
        end
        if (key_hit)
            slots_nx[match_idx] = '0;
        if (spawn_pend && free_ok) begin
            slots_nx[free_idx].active = 1'b1;
            slots_nx[free_idx].ch     = gen_ch;
            slots_nx[free_idx].speed  = (gen_speed == 3'd0) ? 3'd1 : gen_speed;
            slots_nx[free_idx].x      = gen_x;
            slots_nx[free_idx].y      = gen_y;
        end
        miss_sum = {1'b0, miss_cnt} + 17'(miss_n);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            slots      <= '0;
            spawn_cnt  <= '0;
            spawn_pend <= 1'b0;
            score      <= '0;
            miss_cnt   <= '0;
            live_cnt   <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            wrong      <= 1'b0;
        end else begin
            live_cnt <= pop;
            if (run) begin
                slots      <= slots_nx;
                hit        <= key_hit;
                wrong      <= key_valid && !match_ok;
                miss       <= (miss_n != '0);
                miss_cnt   <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
                spawn_pend <= frame_tick && spawn_wrap;
                if (key_hit && score != 16'hFFFF)
                    score <= score + 16'd1;
                if (frame_tick)
                    spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + 1'b1;
            end else begin
                hit   <= 1'b0;
                wrong <= 1'b0;
                miss  <= 1'b0;
            end
        end
    end

    assign rd_active = slots[rd_idx].active;
    assign rd_ch     = slots[rd_idx].ch;
    assign rd_x      = slots[rd_idx].x;
    assign rd_y      = slots[rd_idx].y;

endmodule

// File: tb/tb_letter_pool.sv
// Bench for letter_pool: slot-level game model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_letter_pool;

    localparam int NS = 8;
    localparam int BOT = 480;
    localparam int PER = 2;

    logic       clk, clrn, run, frame_tick, key_valid;
    logic [7:0] gen_ch, key_ascii;
    logic [2:0] gen_speed;
    logic [8:0] gen_x;
    logic [9:0] gen_y;
    logic [2:0] rd_idx;
    logic       rd_active, hit, miss, wrong;
    logic [7:0] rd_ch;
    logic [8:0] rd_x;
    logic [9:0] rd_y;
    logic [15:0] score, miss_cnt;
    logic [3:0] live_cnt;

    letter_pool #(.SLOTS(NS), .BOTTOM(BOT), .SPAWN_PERIOD(PER)) dut (
        .clk(clk), .clrn(clrn), .run(run), .frame_tick(frame_tick),
        .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
        .key_valid(key_valid), .key_ascii(key_ascii), .rd_idx(rd_idx),
        .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
        .hit(hit), .miss(miss), .wrong(wrong), .score(score),
        .miss_cnt(miss_cnt), .live_cnt(live_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: game state as plain integers
    int m_act[NS], m_ch[NS], m_spd[NS], m_x[NS], m_y[NS];
    int m_cnt, m_pend, m_score, m_miss, m_live, m_hit, m_missp, m_wrong;

    // DUT slot snapshots taken by the sweep, used by directed checks
    int s_act[NS], s_ch[NS], s_x[NS], s_y[NS];

    task automatic model_step();
        int win, tgt, nmiss, live;
        live = 0;
        for (int i = 0; i < NS; i++) live += m_act[i];
        if (!clrn) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 0; m_ch[i] = 0; m_spd[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            {m_cnt, m_pend, m_score, m_miss, m_live, m_hit, m_missp, m_wrong} = '0;
            return;
        end
        m_live = live;
        if (!run) begin
            m_hit = 0; m_missp = 0; m_wrong = 0;
            return;
        end
        win = -1;
        if (key_valid)
            for (int i = 0; i < NS; i++)
                if (m_act[i] == 1 && m_ch[i] == int'(key_ascii) && (win < 0 || m_x[i] > m_x[win]))
                    win = i;
        tgt = -1;
        if (m_pend == 1)
            for (int i = NS - 1; i >= 0; i--)
                if (m_act[i] == 0) tgt = i;
        m_hit   = (key_valid && win >= 0) ? 1 : 0;
        m_wrong = (key_valid && win < 0) ? 1 : 0;
        if (m_hit == 1 && m_score < 65535) m_score++;
        nmiss = 0;
        if (frame_tick)
            for (int i = 0; i < NS; i++)
                if (m_act[i] == 1 && i != win) begin
                    if (m_x[i] + m_spd[i] >= BOT) begin
                        m_act[i] = 0;
                        nmiss++;
                    end else m_x[i] += m_spd[i];
                end
        if (win >= 0) m_act[win] = 0;
        m_missp = (nmiss > 0) ? 1 : 0;
        m_miss  = (m_miss + nmiss > 65535) ? 65535 : m_miss + nmiss;
        if (tgt >= 0) begin
            m_act[tgt] = 1; m_ch[tgt] = int'(gen_ch);
            m_spd[tgt] = (gen_speed == 0) ? 1 : int'(gen_speed);
            m_x[tgt] = int'(gen_x); m_y[tgt] = int'(gen_y);
        end
        m_pend = (frame_tick && m_cnt == PER - 1) ? 1 : 0;
        if (frame_tick) m_cnt = (m_cnt + 1) % PER;
    endtask

    // compare process: model update on each edge, then sweep every slot
    initial begin
        rd_idx = '0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("hit", int'(hit), m_hit);
            check("miss", int'(miss), m_missp);
            check("wrong", int'(wrong), m_wrong);
            check("score", int'(score), m_score);
            check("miss_cnt", int'(miss_cnt), m_miss);
            check("live_cnt", int'(live_cnt), m_live);
            for (int i = 0; i < NS; i++) begin
                rd_idx = 3'(i);
                #1;
                s_act[i] = int'(rd_active); s_ch[i] = int'(rd_ch);
                s_x[i] = int'(rd_x); s_y[i] = int'(rd_y);
                check($sformatf("rd_active[%0d]", i), s_act[i], m_act[i]);
                if (m_act[i] == 1) begin
                    check($sformatf("rd_ch[%0d]", i), s_ch[i], m_ch[i]);
                    check($sformatf("rd_x[%0d]", i), s_x[i], m_x[i]);
                    check($sformatf("rd_y[%0d]", i), s_y[i], m_y[i]);
                end
            end
        end
    end

    task automatic cyc(input bit t, input bit kv, input logic [7:0] k);
        frame_tick = t;
        key_valid  = kv;
        key_ascii  = k;
        @(negedge clk);
    endtask

    task automatic gen(input logic [7:0] c, input logic [2:0] s, input logic [8:0] x, input logic [9:0] y);
        gen_ch = c; gen_speed = s; gen_x = x; gen_y = y;
    endtask

    initial begin
        clrn = 1'b0; run = 1'b0; frame_tick = 1'b0; key_valid = 1'b0; key_ascii = '0;
        gen(8'h4B, 3'd3, 9'd0, 10'd100);
        repeat (3) @(negedge clk);
        check("rst score", int'(score), 0);
        check("rst live", int'(live_cnt), 0);
        check("rst slot0", s_act[0], 0);
        clrn = 1'b1;
        run  = 1'b1;

        // first spawn after PER ticks, then one move
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        check("spawn0 act", s_act[0], 1);
        check("spawn0 ch", s_ch[0], 8'h4B);
        check("spawn0 x", s_x[0], 0);
        check("spawn0 y", s_y[0], 100);
        cyc(1, 0, 0);
        check("move0 x", s_x[0], 3);
        check("move0 live", int'(live_cnt), 1);

        // bottom miss
        gen(8'h4D, 3'd2, 9'd478, 10'd5);
        cyc(1, 0, 0); cyc(0, 0, 0);
        check("s1 x", s_x[1], 478);
        cyc(1, 0, 0);
        check("miss pulse", int'(miss), 1);
        check("miss_cnt", int'(miss_cnt), 1);
        check("miss cleared", s_act[1], 0);
        cyc(0, 0, 0);
        check("miss one-shot", int'(miss), 0);

        // 'A' letters: slot1 x40, slot2 x10, slot3 x40 (speed 0 stored as 1)
        gen(8'h41, 3'd0, 9'd36, 10'd200);
        cyc(1, 0, 0); cyc(0, 0, 0);
        gen(8'h41, 3'd0, 9'd8, 10'd210);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        gen(8'h41, 3'd0, 9'd40, 10'd220);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        check("A1 x", s_x[1], 40);
        check("A2 x", s_x[2], 10);
        check("A3 x", s_x[3], 40);
        cyc(0, 1, 8'h41);
        check("hitA pulse", int'(hit), 1);
        check("hitA score", int'(score), 1);
        check("hitA tie slot1", s_act[1], 0);
        check("hitA slot3 kept", s_act[3], 1);
        cyc(0, 1, 8'h5A);
        check("wrong pulse", int'(wrong), 1);
        check("wrong no hit", int'(hit), 0);
        check("wrong live", int'(live_cnt), 3);

        // frozen game
        run = 1'b0;
        cyc(1, 1, 8'h41);
        check("frz hit", int'(hit), 0);
        check("frz x3", s_x[3], 40);
        check("frz act3", s_act[3], 1);
        run = 1'b1;

        // fill every slot, then a spawn with nowhere to go
        gen(8'h42, 3'd1, 9'd0, 10'd300);
        for (int n = 0; n < 5; n++) begin
            cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        end
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        check("full live", int'(live_cnt), 8);
        cyc(0, 1, 8'h4B);
        cyc(0, 0, 0);
        check("dropped spawn", s_act[0], 0);
        gen(8'h43, 3'd1, 9'd0, 10'd310);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        check("refill act", s_act[0], 1);
        check("refill ch", s_ch[0], 8'h43);

        // key hit on a letter about to fall out, same cycle as the tick
        cyc(0, 1, 8'h43);
        gen(8'h51, 3'd2, 9'd478, 10'd400);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        check("Q x", s_x[0], 478);
        cyc(1, 1, 8'h51);
        check("Q hit", int'(hit), 1);
        check("Q score", int'(score), 4);
        check("Q no miss", int'(miss), 0);
        check("Q miss_cnt", int'(miss_cnt), 1);
        check("Q cleared", s_act[0], 0);

        // reach 5 live / score 7, then asynchronous reset
        gen(8'h44, 3'd1, 9'd0, 10'd0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 8'h41); cyc(0, 1, 8'h41); cyc(0, 1, 8'h42);
        cyc(0, 0, 0);
        check("pre live", int'(live_cnt), 5);
        check("pre score", int'(score), 7);
        cyc(0, 1, 8'h5A);
        check("pre wrong", int'(wrong), 1);
        #3;
        clrn = 1'b0;
        #1;
        check("arst wrong", int'(wrong), 0);
        check("arst score", int'(score), 0);
        check("arst live", int'(live_cnt), 0);
        check("arst miss_cnt", int'(miss_cnt), 0);
        check("arst rd_active", int'(rd_active), 0);
        @(negedge clk);
        clrn = 1'b1;
        cyc(1, 0, 0); cyc(0, 0, 0);
        check("post rst no spawn", s_act[0], 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        check("post rst spawn", s_act[0], 1);
        cyc(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
